fetch_top: RTL

//  IF stage: owns the PC, drives synchronous instruction memory, presents if_inst + branch prediction to decode.

---
 rtl/fetch_top.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_top.sv
// fetch_top: IF stage owning the PC, issuing synchronous imem reads and predicting JAL/B-type in-stage.
// Define FETCH_BHT_EN for a 2-bit BHT predictor; otherwise static BTFN on B-type.
module fetch_top #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BHT_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        intrlock_bubble,
   input  logic        ex_branch_flush,
   input  logic [31:0] ex_redirect_pc,
   input  logic        ex_bht_upd_vld,
   input  logic [31:0] ex_bht_upd_pc,
   input  logic        ex_bht_upd_taken,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_branch_taken,
   output logic [31:0] if_branch_nt_pc
);

   localparam logic [31:0] BUBBLE = 32'h0000_0013;
   localparam logic [6:0]  OP_JAL = 7'b1101111;
   localparam logic [6:0]  OP_BR  = 7'b1100011;

   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic [31:0] inst;
   logic [31:0] b_imm;
   logic [31:0] j_imm;
   logic [31:0] target;
   logic        pred_q;
   logic        hold_q;
   logic        is_jal;
   logic        is_br;
   logic        br_pred;
   logic        cur_pred;
   logic        pred_eff;
   logic        kill;
   logic        unused_bht;

   assign inst     = imem_rdata;
   assign is_jal   = (inst[6:0] == OP_JAL);
   assign is_br    = (inst[6:0] == OP_BR);
   assign b_imm    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign j_imm    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign target   = is_jal ? (pc_q + j_imm) : (pc_q + b_imm);
   assign cur_pred = is_jal | (is_br & br_pred);
   // A held prediction stays authoritative for the whole stall so a BHT update cannot flip it.
   assign pred_eff = hold_q ? pred_q : cur_pred;

`ifdef FETCH_BHT_EN
   localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       bht [BHT_DEPTH];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] upd_idx;

   assign rd_idx     = pc_q[IDX_W+1:2];
   assign upd_idx    = ex_bht_upd_pc[IDX_W+1:2];
   assign br_pred    = bht[rd_idx][1];
   assign unused_bht = ^ex_bht_upd_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            bht[i[IDX_W-1:0]] <= 2'b01;
         end
      end else if (ex_bht_upd_vld) begin
         if (ex_bht_upd_taken) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
         end
      end
   end
`else
   assign br_pred    = inst[31];
   assign unused_bht = ^{ex_bht_upd_vld, ex_bht_upd_pc, ex_bht_upd_taken};
`endif

   always_comb begin
      pc_nxt = pc_q + 32'd4;
      if (rst)                  pc_nxt = RESET_PC;
      else if (ex_branch_flush) pc_nxt = ex_redirect_pc;
      else if (intrlock_bubble) pc_nxt = pc_q;
      else if (pred_eff)        pc_nxt = target;
      pc_nxt[1:0] = 2'b00;
   end

   assign kill            = rst | ex_branch_flush;
   assign imem_addr       = pc_nxt;
   assign if_inst         = kill ? BUBBLE : inst;
   assign if_pc           = rst ? RESET_PC : pc_q;
   assign if_branch_nt_pc = rst ? (RESET_PC + 32'd4) : (pc_q + 32'd4);
   assign if_branch_taken = ~kill & pred_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         pred_q <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         pc_q <= pc_nxt;
         if (ex_branch_flush) begin
            hold_q <= 1'b0;
         end else if (intrlock_bubble) begin
            if (!hold_q) begin
               pred_q <= cur_pred;
               hold_q <= 1'b1;
            end
         end else begin
            hold_q <= 1'b0;
         end
      end
   end

endmodule
